// File: rtl/bp_be_stride_detector.sv
// ============================================================================
// Module   : bp_be_stride_detector
// Purpose  : Per-PC load stride training table driving loop-inference discovery
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_be_stride_detector #(
  // Default matches the processor's standard configuration vaddr width
  parameter int unsigned vaddr_width_p    = 39,
  parameter int unsigned entries_p        = 16,
  parameter int unsigned start_thresh_p   = 2,
  parameter int unsigned confirm_thresh_p = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_v_i,
  input  logic [vaddr_width_p-1:0] load_pc_i,
  input  logic [vaddr_width_p-1:0] load_vaddr_i,
  input  logic                     done_i,
  output logic                     start_discovery_o,
  output logic                     confirm_discovery_o,
  output logic [vaddr_width_p-1:0] striding_pc_o,
  output logic [vaddr_width_p-1:0] stride_o,
  output logic                     tracking_o
);

  localparam int unsigned c_LG_ENTRIES = $clog2(entries_p);
  localparam logic [1:0]  c_START_THR  = start_thresh_p[1:0];
  localparam logic [1:0]  c_CONF_THR   = confirm_thresh_p[1:0];
  localparam logic [1:0]  c_CONF_MAX   = 2'd3;

  // Stage 0: captured committed load
  logic                     load_v_q;
  logic [vaddr_width_p-1:0] load_pc_q;
  logic [vaddr_width_p-1:0] load_vaddr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_v_q     <= 1'b0;
      load_pc_q    <= '0;
      load_vaddr_q <= '0;
    end else begin
      load_v_q     <= load_v_i;
      load_pc_q    <= load_pc_i;
      load_vaddr_q <= load_vaddr_i;
    end
  end

  // Training table
  logic [entries_p-1:0]     valid_q;
  logic [vaddr_width_p-1:0] tag_q    [entries_p];
  logic [vaddr_width_p-1:0] last_q   [entries_p];
  logic [vaddr_width_p-1:0] stride_q [entries_p];
  logic [1:0]               conf_q   [entries_p];

  logic [c_LG_ENTRIES-1:0]  w_idx;
  logic                     w_hit;
  logic                     w_match;
  logic [vaddr_width_p-1:0] w_delta;
  logic [vaddr_width_p-1:0] w_stride_new;
  logic [1:0]               w_conf_new;

  assign w_idx   = load_pc_q[1 +: c_LG_ENTRIES];
  assign w_hit   = valid_q[w_idx] && (tag_q[w_idx] == load_pc_q);
  assign w_delta = load_vaddr_q - last_q[w_idx];
  assign w_match = w_hit && (w_delta == stride_q[w_idx]) && (w_delta != '0);

  always_comb begin
    w_stride_new = '0;
    w_conf_new   = 2'd0;
    if (w_hit) begin
      w_stride_new = w_delta;
      if (w_match) begin
        w_conf_new = (conf_q[w_idx] == c_CONF_MAX) ? c_CONF_MAX : conf_q[w_idx] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
    end else if (load_v_q) begin
      valid_q[w_idx] <= 1'b1;
    end
  end

  // Data fields need no reset; valid bits gate every use
  always_ff @(posedge clk_i) begin
    if (load_v_q) begin
      tag_q[w_idx]    <= load_pc_q;
      last_q[w_idx]   <= load_vaddr_q;
      stride_q[w_idx] <= w_stride_new;
      conf_q[w_idx]   <= w_conf_new;
    end
  end

  // Discovery handshake
  logic                     tracking_q, tracking_d;
  logic                     confirmed_q, confirmed_d;
  logic [vaddr_width_p-1:0] striding_pc_q, striding_pc_d;
  logic [vaddr_width_p-1:0] stride_out_q, stride_out_d;
  logic                     start_q, confirm_q;
  logic                     w_start, w_confirm;

  assign w_start   = load_v_q && !tracking_q && !done_i && (w_conf_new >= c_START_THR);
  assign w_confirm = load_v_q && tracking_q && !confirmed_q && !done_i
                     && (load_pc_q == striding_pc_q) && (w_conf_new >= c_CONF_THR);

  always_comb begin
    tracking_d    = tracking_q;
    confirmed_d   = confirmed_q;
    striding_pc_d = striding_pc_q;
    stride_out_d  = stride_out_q;
    if (w_start) begin
      tracking_d    = 1'b1;
      confirmed_d   = 1'b0;
      striding_pc_d = load_pc_q;
      stride_out_d  = w_delta;
    end
    if (w_confirm) begin
      confirmed_d = 1'b1;
    end
    if (done_i) begin
      tracking_d  = 1'b0;
      confirmed_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tracking_q    <= 1'b0;
      confirmed_q   <= 1'b0;
      striding_pc_q <= '0;
      stride_out_q  <= '0;
      start_q       <= 1'b0;
      confirm_q     <= 1'b0;
    end else begin
      tracking_q    <= tracking_d;
      confirmed_q   <= confirmed_d;
      striding_pc_q <= striding_pc_d;
      stride_out_q  <= stride_out_d;
      start_q       <= w_start;
      confirm_q     <= w_confirm;
    end
  end

  assign start_discovery_o   = start_q;
  assign confirm_discovery_o = confirm_q;
  assign striding_pc_o       = striding_pc_q;
  assign stride_o            = stride_out_q;
  assign tracking_o          = tracking_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_be_stride_detector.sv
// ============================================================================
// Module   : tb_bp_be_stride_detector
// Purpose  : Directed self-checking bench for bp_be_stride_detector
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_be_stride_detector;

  localparam int unsigned VW = 39;
  localparam logic [VW-1:0] NEG16 = 39'h7FFFFFFFF0;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          load_v_i;
  logic [VW-1:0] load_pc_i;
  logic [VW-1:0] load_vaddr_i;
  logic          done_i;
  logic          start_discovery_o;
  logic          confirm_discovery_o;
  logic [VW-1:0] striding_pc_o;
  logic [VW-1:0] stride_o;
  logic          tracking_o;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;
  int n_conf   = 0;
  int s0, c0;

  bp_be_stride_detector #(
    .vaddr_width_p(VW), .entries_p(16), .start_thresh_p(2), .confirm_thresh_p(3)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .load_v_i(load_v_i), .load_pc_i(load_pc_i),
    .load_vaddr_i(load_vaddr_i), .done_i(done_i),
    .start_discovery_o(start_discovery_o), .confirm_discovery_o(confirm_discovery_o),
    .striding_pc_o(striding_pc_o), .stride_o(stride_o), .tracking_o(tracking_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (start_discovery_o) n_start++;
    if (confirm_discovery_o) n_conf++;
  endtask

  task automatic do_load(input logic [VW-1:0] pc, input logic [VW-1:0] va);
    load_v_i = 1'b1; load_pc_i = pc; load_vaddr_i = va;
    tick();
    load_v_i = 1'b0;
  endtask

  task automatic idle();
    load_v_i = 1'b0;
    tick();
  endtask

  task automatic pulse_done();
    load_v_i = 1'b0; done_i = 1'b1;
    tick();
    done_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; load_v_i = 1'b0; done_i = 1'b0; load_pc_i = '0; load_vaddr_i = '0;
    tick(); tick();
    checks++;
    if ({start_discovery_o, confirm_discovery_o, tracking_o} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {start_discovery_o, confirm_discovery_o, tracking_o});
    end
    checks++;
    if (striding_pc_o !== '0 || stride_o !== '0) begin
      failures++; $display("FAIL reset_regs got pc=%h stride=%h exp=0", striding_pc_o, stride_o);
    end
    reset_i = 1'b0;
    tick();
    n_start = 0; n_conf = 0;
  endtask

  task automatic test_pos_stride();
    do_load(39'h1000, 39'h8000);
    do_load(39'h1000, 39'h8008);
    do_load(39'h1000, 39'h8010);
    do_load(39'h1000, 39'h8018);
    checks++;
    if (start_discovery_o !== 1'b0) begin
      failures++; $display("FAIL pos_early_start got=%b exp=0", start_discovery_o);
    end
    do_load(39'h1000, 39'h8020);
    checks++;
    if (start_discovery_o !== 1'b1 || confirm_discovery_o !== 1'b0) begin
      failures++; $display("FAIL pos_start got s=%b c=%b exp s=1 c=0", start_discovery_o, confirm_discovery_o);
    end
    checks++;
    if (striding_pc_o !== 39'h1000 || stride_o !== 39'h8 || tracking_o !== 1'b1) begin
      failures++; $display("FAIL pos_fields got pc=%h stride=%h trk=%b exp pc=1000 stride=8 trk=1", striding_pc_o, stride_o, tracking_o);
    end
    idle();
    checks++;
    if (confirm_discovery_o !== 1'b1 || start_discovery_o !== 1'b0) begin
      failures++; $display("FAIL pos_confirm got s=%b c=%b exp s=0 c=1", start_discovery_o, confirm_discovery_o);
    end
    s0 = n_start; c0 = n_conf;
    repeat (4) idle();
    checks++;
    if (n_start !== s0 || n_conf !== c0) begin
      failures++; $display("FAIL pos_quiet got starts=%0d confs=%0d exp starts=%0d confs=%0d", n_start, n_conf, s0, c0);
    end
  endtask

  task automatic test_neg_stride();
    pulse_done();
    checks++;
    if (tracking_o !== 1'b0) begin
      failures++; $display("FAIL neg_done_clear got=%b exp=0", tracking_o);
    end
    do_load(39'h1004, 39'h9000);
    do_load(39'h1004, 39'h8FF0);
    do_load(39'h1004, 39'h8FE0);
    do_load(39'h1004, 39'h8FD0);
    idle();
    checks++;
    if (start_discovery_o !== 1'b1 || stride_o !== NEG16 || striding_pc_o !== 39'h1004) begin
      failures++; $display("FAIL neg_start got s=%b stride=%h pc=%h exp s=1 stride=%h pc=1004", start_discovery_o, stride_o, striding_pc_o, NEG16);
    end
    do_load(39'h1004, 39'h8FD0);
    idle();
    checks++;
    if (tracking_o !== 1'b1 || confirm_discovery_o !== 1'b0) begin
      failures++; $display("FAIL neg_zero_delta got trk=%b c=%b exp trk=1 c=0", tracking_o, confirm_discovery_o);
    end
    c0 = n_conf;
    do_load(39'h1004, 39'h8FC0);
    do_load(39'h1004, 39'h8FB0);
    do_load(39'h1004, 39'h8FA0);
    idle();
    checks++;
    if (n_conf !== c0) begin
      failures++; $display("FAIL neg_retrain_early got confs=%0d exp=%0d", n_conf, c0);
    end
    do_load(39'h1004, 39'h8F90);
    idle();
    checks++;
    if (confirm_discovery_o !== 1'b1 || stride_o !== NEG16) begin
      failures++; $display("FAIL neg_retrain_confirm got c=%b stride=%h exp c=1 stride=%h", confirm_discovery_o, stride_o, NEG16);
    end
  endtask

  task automatic test_other_pc();
    pulse_done();
    do_load(39'h1000, 39'h8028);
    idle();
    checks++;
    if (start_discovery_o !== 1'b1 || striding_pc_o !== 39'h1000) begin
      failures++; $display("FAIL other_first_start got s=%b pc=%h exp s=1 pc=1000", start_discovery_o, striding_pc_o);
    end
    s0 = n_start;
    for (int k = 0; k < 5; k++) do_load(39'h2000, 39'h100 + 39'(4 * k));
    idle(); idle();
    checks++;
    if (n_start !== s0 || tracking_o !== 1'b1 || striding_pc_o !== 39'h1000) begin
      failures++; $display("FAIL other_blocked got starts=%0d trk=%b pc=%h exp starts=%0d trk=1 pc=1000", n_start, tracking_o, striding_pc_o, s0);
    end
    pulse_done();
    do_load(39'h2000, 39'h114);
    idle();
    checks++;
    if (start_discovery_o !== 1'b1 || striding_pc_o !== 39'h2000 || stride_o !== 39'h4) begin
      failures++; $display("FAIL other_restart got s=%b pc=%h stride=%h exp s=1 pc=2000 stride=4", start_discovery_o, striding_pc_o, stride_o);
    end
  endtask

  task automatic test_done_collision();
    pulse_done();
    s0 = n_start;
    do_load(39'h2000, 39'h118);
    pulse_done();
    checks++;
    if (tracking_o !== 1'b0 || start_discovery_o !== 1'b0) begin
      failures++; $display("FAIL collide_drop got trk=%b s=%b exp trk=0 s=0", tracking_o, start_discovery_o);
    end
    idle();
    checks++;
    if (n_start !== s0 || tracking_o !== 1'b0) begin
      failures++; $display("FAIL collide_quiet got starts=%0d trk=%b exp starts=%0d trk=0", n_start, tracking_o, s0);
    end
    do_load(39'h2000, 39'h11C);
    idle();
    checks++;
    if (start_discovery_o !== 1'b1 || tracking_o !== 1'b1) begin
      failures++; $display("FAIL collide_restart got s=%b trk=%b exp s=1 trk=1", start_discovery_o, tracking_o);
    end
  endtask

  task automatic test_alias();
    pulse_done();
    s0 = n_start;
    for (int k = 0; k < 6; k++) begin
      do_load(39'h1000, 39'h8000 + 39'(8 * k));
      do_load(39'h1020, 39'hA000 + 39'(8 * k));
    end
    idle(); idle();
    checks++;
    if (n_start !== s0 || tracking_o !== 1'b0) begin
      failures++; $display("FAIL alias_no_start got starts=%0d trk=%b exp starts=%0d trk=0", n_start, tracking_o, s0);
    end
  endtask

  task automatic test_reset_mid();
    s0 = n_start;
    do_load(39'h1008, 39'h4000);
    do_load(39'h1008, 39'h4010);
    do_load(39'h1008, 39'h4020);
    do_load(39'h1008, 39'h4030);
    reset_i = 1'b1; done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checks++;
    if ({start_discovery_o, confirm_discovery_o, tracking_o} !== 3'b000 || striding_pc_o !== '0 || stride_o !== '0) begin
      failures++; $display("FAIL midreset_outputs got flags=%b pc=%h stride=%h exp all 0", {start_discovery_o, confirm_discovery_o, tracking_o}, striding_pc_o, stride_o);
    end
    reset_i = 1'b0;
    idle();
    checks++;
    if (n_start !== s0) begin
      failures++; $display("FAIL midreset_no_start got starts=%0d exp=%0d", n_start, s0);
    end
    do_load(39'h1008, 39'h4040);
    do_load(39'h1008, 39'h4050);
    do_load(39'h1008, 39'h4060);
    idle();
    checks++;
    if (n_start !== s0) begin
      failures++; $display("FAIL midreset_retrain_early got starts=%0d exp=%0d", n_start, s0);
    end
    do_load(39'h1008, 39'h4070);
    idle();
    checks++;
    if (start_discovery_o !== 1'b1 || striding_pc_o !== 39'h1008 || stride_o !== 39'h10) begin
      failures++; $display("FAIL midreset_retrain got s=%b pc=%h stride=%h exp s=1 pc=1008 stride=10", start_discovery_o, striding_pc_o, stride_o);
    end
  endtask

  initial begin
    test_reset();
    test_pos_stride();
    test_neg_stride();
    test_other_pc();
    test_done_collision();
    test_alias();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
